// File: rtl/base_wayfifo_bank.sv
// base_wayfifo_bank
//   Bank of independent per-way FIFOs placed after a priority demultiplexer.
//   Every way sees the shared broadcast data word and its own push valid, and
//   buffers entries in a private circular buffer. Push ready depends only on
//   the way's own occupancy, so consumer ready never reaches the demux
//   combinationally.
//
//   Optional feature macro: BASE_WAYFIFO_BYPASS_EN
//     When it is defined, a push into an empty way is presented on o_v/o_d in
//     the same cycle. If the consumer takes it in that cycle, nothing is stored.
//     When it is undefined, a pushed entry appears on o_v one cycle later.
//
//   Handshake: a transfer happens on a port in every cycle where valid and
//   ready are both high. On the push side valid may be raised without waiting
//   for ready. A push that arrives while ready is low, or while more than one
//   i_v bit is set, is dropped and leaves the FIFO state unchanged.
//
// Ports
//   clk    : clock. All state is updated on the rising edge.
//   rstn   : asynchronous, active-low reset.
//   i_v    : per-way push valid. At most one bit is set in a legal cycle.
//   i_r    : per-way push ready, equal to rstn & (count != depth).
//   i_d    : broadcast push data, shared by all ways.
//   o_v    : per-way head valid.
//   o_r    : per-way consumer ready.
//   o_d    : per-way head data. Way w is at bits [w*width : w*width+width-1].
//   o_cnt  : per-way registered occupancy. Way w is at bits [w*cntw : w*cntw+cntw-1].
module base_wayfifo_bank #(
    parameter int ways  = 2,
    parameter int width = 1,
    parameter int depth = 2,
    parameter int cntw  = $clog2(depth + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [0:ways-1]         i_v,
    output logic [0:ways-1]         i_r,
    input  logic [0:width-1]        i_d,
    output logic [0:ways-1]         o_v,
    input  logic [0:ways-1]         o_r,
    output logic [0:ways*width-1]   o_d,
    output logic [0:ways*cntw-1]    o_cnt
);

    localparam int ptrw = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [cntw-1:0] full_cnt = cntw'(depth);
    localparam logic [ptrw-1:0] last_ptr = ptrw'(depth - 1);

    // Pushes are accepted only when exactly one way is being addressed.
    // If several valid bits are set, that cycle's data is dropped for every way.
    logic push_legal;
    assign push_legal = $onehot(i_v);

    for (genvar w = 0; w < ways; w++) begin : g_way
        logic [width-1:0] mem [depth];
        logic [ptrw-1:0]  rd;
        logic [ptrw-1:0]  wr;
        logic [cntw-1:0]  cnt;
        logic             rdy;
        logic             push;
        logic             pop;
        logic             wr_en;
        logic             has_data;
        logic [width-1:0] head;

        assign rdy      = rstn & (cnt != full_cnt);
        assign push     = i_v[w] & rdy & push_legal;
        assign has_data = (cnt != '0);
        // A pop only ever takes a stored entry. The bypass path never moves rd.
        assign pop      = has_data & o_r[w];

`ifdef BASE_WAYFIFO_BYPASS_EN
        logic byp;
        assign byp    = push & ~has_data;
        // An entry consumed straight from the bypass path is not written.
        assign wr_en  = push & ~(byp & o_r[w]);
        assign o_v[w] = has_data | byp;
        assign head   = has_data ? mem[rd] : i_d;
`else
        assign wr_en  = push;
        assign o_v[w] = has_data;
        assign head   = mem[rd];
`endif

        assign i_r[w]                  = rdy;
        assign o_d[w*width +: width]   = head;
        assign o_cnt[w*cntw +: cntw]   = cnt;

        // The storage array has no reset. The entries are qualified by cnt.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr] <= i_d;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rd  <= '0;
                wr  <= '0;
                cnt <= '0;
            end else begin
                if (wr_en) begin
                    wr <= (wr == last_ptr) ? '0 : wr + ptrw'(1);
                end
                if (pop) begin
                    rd <= (rd == last_ptr) ? '0 : rd + ptrw'(1);
                end
                case ({wr_en, pop})
                    2'b10:   cnt <= cnt + cntw'(1);
                    2'b01:   cnt <= cnt - cntw'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_base_wayfifo_bank.sv
module tb_base_wayfifo_bank;

  localparam int WAYS  = 2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNTW  = $clog2(DEPTH + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [0:WAYS-1]       i_v;
  logic [0:WAYS-1]       i_r;
  logic [0:WIDTH-1]      i_d;
  logic [0:WAYS-1]       o_v;
  logic [0:WAYS-1]       o_r;
  logic [0:WAYS*WIDTH-1] o_d;
  logic [0:WAYS*CNTW-1]  o_cnt;

  base_wayfifo_bank #(
    .ways (WAYS),
    .width(WIDTH),
    .depth(DEPTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .i_v  (i_v),
    .i_r  (i_r),
    .i_d  (i_d),
    .o_v  (o_v),
    .o_r  (o_r),
    .o_d  (o_d),
    .o_cnt(o_cnt)
  );

  // per-way views of the packed outputs
  logic [7:0] d0, d1;
  logic [1:0] cnt0, cnt1;
  assign d0   = o_d[0:7];
  assign d1   = o_d[8:15];
  assign cnt0 = o_cnt[0:1];
  assign cnt1 = o_cnt[2:3];

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive inputs and let combinational outputs settle
  task automatic drive(input logic [0:1] v, input logic [7:0] d, input logic [0:1] r);
    i_v = v;
    i_d = d;
    o_r = r;
    #1;
  endtask

  initial begin
    i_v = 2'b11;
    i_d = 8'h00;
    o_r = 2'b00;

    // reset with both valids high
    tick();
    tick();
    check_eq("rst_o_v", o_v, 2'b00);
    check_eq("rst_i_r", i_r, 2'b00);
    check_eq("rst_cnt", o_cnt, 4'h0);
    rstn = 1'b1;
    drive(2'b00, 8'h00, 2'b00);
    tick();
    check_eq("post_rst_i_r", i_r, 2'b11);
    check_eq("post_rst_o_v", o_v, 2'b00);
    check_eq("post_rst_cnt", o_cnt, 4'h0);

    // fill way 0 with A1 and A2
    drive(2'b10, 8'hA1, 2'b00);
    tick();
    check_eq("fill1_cnt0", cnt0, 2'd1);
    check_eq("fill1_o_v", o_v, 2'b10);
    check_eq("fill1_d0", d0, 8'hA1);
    drive(2'b10, 8'hA2, 2'b00);
    tick();
    drive(2'b00, 8'h00, 2'b00);
    check_eq("fill2_cnt0", cnt0, 2'd2);
    check_eq("fill2_i_r", i_r, 2'b01);
    check_eq("fill2_d0", d0, 8'hA1);
    check_eq("fill2_cnt1", cnt1, 2'd0);

    // drain in order
    drive(2'b00, 8'h00, 2'b10);
    check_eq("drain_head1", d0, 8'hA1);
    tick();
    check_eq("drain_cnt_a", cnt0, 2'd1);
    check_eq("drain_head2", d0, 8'hA2);
    tick();
    drive(2'b00, 8'h00, 2'b00);
    check_eq("drain_cnt_b", cnt0, 2'd0);
    check_eq("drain_o_v", o_v, 2'b00);
    check_eq("drain_i_r", i_r, 2'b11);

    // simultaneous push and pop at count 1
    drive(2'b10, 8'h11, 2'b00);
    tick();
    check_eq("pp_pre_head", d0, 8'h11);
    drive(2'b10, 8'h55, 2'b10);
    tick();
    drive(2'b00, 8'h00, 2'b00);
    check_eq("pp_cnt0", cnt0, 2'd1);
    check_eq("pp_head", d0, 8'h55);

    // full, with push and pop requested together
    drive(2'b10, 8'h66, 2'b00);
    tick();
    check_eq("full_cnt0", cnt0, 2'd2);
    drive(2'b10, 8'h77, 2'b10);
    check_eq("full_i_r0", i_r[0], 1'b0);
    tick();
    drive(2'b00, 8'h00, 2'b00);
    check_eq("fullpop_cnt0", cnt0, 2'd1);
    check_eq("fullpop_i_r0", i_r[0], 1'b1);
    check_eq("fullpop_head", d0, 8'h66);
    drive(2'b00, 8'h00, 2'b10);
    tick();
    drive(2'b00, 8'h00, 2'b00);
    check_eq("empty0_cnt", cnt0, 2'd0);
    check_eq("empty0_o_v", o_v[0], 1'b0);

    // push to empty way 1 with the consumer ready
    drive(2'b01, 8'h3C, 2'b01);
`ifdef BASE_WAYFIFO_BYPASS_EN
    check_eq("byp_o_v_same", o_v, 2'b01);
    check_eq("byp_d1_same", d1, 8'h3C);
    tick();
    drive(2'b00, 8'h00, 2'b00);
    check_eq("byp_cnt1", cnt1, 2'd0);
    check_eq("byp_o_v_next", o_v, 2'b00);
`else
    check_eq("nobyp_o_v_same", o_v, 2'b00);
    tick();
    drive(2'b00, 8'h00, 2'b01);
    check_eq("nobyp_o_v_next", o_v, 2'b01);
    check_eq("nobyp_d1_next", d1, 8'h3C);
    check_eq("nobyp_cnt1", cnt1, 2'd1);
    tick();
    drive(2'b00, 8'h00, 2'b00);
    check_eq("nobyp_cnt1_drain", cnt1, 2'd0);
`endif

    // two valid bits at once are dropped in both ways
    drive(2'b11, 8'hEE, 2'b00);
    check_eq("multi_o_v_same", o_v, 2'b00);
    tick();
    drive(2'b00, 8'h00, 2'b00);
    check_eq("multi_cnt", o_cnt, 4'h0);

    // reset asserted mid-operation
    drive(2'b01, 8'h99, 2'b00);
    tick();
    drive(2'b00, 8'h00, 2'b00);
    check_eq("pre_midrst_cnt1", cnt1, 2'd1);
    rstn = 1'b0;
    #1;
    check_eq("midrst_o_v", o_v, 2'b00);
    check_eq("midrst_cnt", o_cnt, 4'h0);
    check_eq("midrst_i_r", i_r, 2'b00);
    tick();
    rstn = 1'b1;
    tick();
    check_eq("after_midrst_i_r", i_r, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
